// File: rtl/usb_data_buffer.sv
// Shared 64-byte circular FIFO between the USB RX/TX packet engines and the AHB-Lite slave.
// First-word fall-through read, arbitrated push/pop, sticky overrun/underrun flags.
module usb_data_buffer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              store_tx_data,
   input  logic [7:0]        tx_data,
   input  logic              get_rx_data,
   output logic [7:0]        rx_data,
   input  logic              store_rx_packet_data,
   input  logic [7:0]        rx_packet_data,
   input  logic              get_tx_packet_data,
   output logic [7:0]        tx_packet_data,
   output logic [ADDR_W:0]   buffer_occupancy,
   output logic              overrun,
   output logic              underrun
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              overrun_reg, overrun_next;
   logic              underrun_reg, underrun_next;

   logic       push, pop, empty, full;
   logic       push_ok, pop_ok;
   logic [7:0] wr_byte;

   assign push    = store_rx_packet_data | store_tx_data;
   assign pop     = get_tx_packet_data | get_rx_data;
   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_COUNT);
   // No empty bypass: a pop on an empty buffer is refused even when a push arrives with it.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overrun_next  = overrun_reg;
      underrun_next = underrun_reg;

      if (clear) begin
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         overrun_next  = 1'b0;
         underrun_next = 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
         if (pop_ok)
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
         if (push_ok && !pop_ok)
            count_next = count_reg + (ADDR_W+1)'(1);
         else if (pop_ok && !push_ok)
            count_next = count_reg - (ADDR_W+1)'(1);
         // Both push strobes together always loses the AHB byte, even if the RX byte lands.
         if ((push && !push_ok) || (store_rx_packet_data && store_tx_data))
            overrun_next = 1'b1;
         if (pop && !pop_ok)
            underrun_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overrun_reg  <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overrun_reg  <= overrun_next;
         underrun_reg <= underrun_next;
      end
   end

   // Storage is never reset; writes during rst/clear land in entries that are abandoned anyway.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= wr_byte;
   end

   assign rx_data          = empty ? 8'h00 : mem[rd_ptr_reg];
   assign tx_packet_data   = empty ? 8'h00 : mem[rd_ptr_reg];
   assign buffer_occupancy = count_reg;
   assign overrun          = overrun_reg;
   assign underrun         = underrun_reg;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: a queue scoreboard models the FIFO contents
// and flags, and each scenario task compares DUT outputs against it inline.
module tb_usb_data_buffer;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       store_tx_data;
   logic [7:0] tx_data;
   logic       get_rx_data;
   logic [7:0] rx_data;
   logic       store_rx_packet_data;
   logic [7:0] rx_packet_data;
   logic       get_tx_packet_data;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       overrun;
   logic       underrun;

   int errors = 0;
   int checks = 0;

   logic [7:0] model[$];
   logic       model_ovf;
   logic       model_unf;

   usb_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .clear                (clear),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .get_rx_data          (get_rx_data),
      .rx_data              (rx_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .tx_packet_data       (tx_packet_data),
      .buffer_occupancy     (buffer_occupancy),
      .overrun              (overrun),
      .underrun             (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
      $fatal(1, "watchdog");
   end

   // One clock of stimulus, then the scoreboard is advanced using the buffer rules.
   task automatic drive(input logic s_rx, input logic [7:0] d_rx,
                        input logic s_tx, input logic [7:0] d_tx,
                        input logic g_rx, input logic g_tx, input logic clr);
      logic p_push, p_pop, p_pop_ok, p_push_ok;
      store_rx_packet_data = s_rx;
      rx_packet_data       = d_rx;
      store_tx_data        = s_tx;
      tx_data              = d_tx;
      get_rx_data          = g_rx;
      get_tx_packet_data   = g_tx;
      clear                = clr;
      @(posedge clk);
      #1;
      store_rx_packet_data = 1'b0;
      store_tx_data        = 1'b0;
      get_rx_data          = 1'b0;
      get_tx_packet_data   = 1'b0;
      clear                = 1'b0;
      if (clr) begin
         model.delete();
         model_ovf = 1'b0;
         model_unf = 1'b0;
      end else begin
         p_push    = s_rx | s_tx;
         p_pop     = g_rx | g_tx;
         p_pop_ok  = p_pop && (model.size() > 0);
         p_push_ok = p_push && ((model.size() < 64) || p_pop_ok);
         if (p_pop_ok)
            void'(model.pop_front());
         if (p_push_ok)
            model.push_back(s_rx ? d_rx : d_tx);
         if ((p_push && !p_push_ok) || (s_rx && s_tx))
            model_ovf = 1'b1;
         if (p_pop && !p_pop_ok)
            model_unf = 1'b1;
      end
      $display("txn t=%0t srx=%0b/%02h stx=%0b/%02h grx=%0b gtx=%0b clr=%0b -> occ=%0d head=%02h ovf=%0b unf=%0b",
               $time, s_rx, d_rx, s_tx, d_tx, g_rx, g_tx, clr,
               buffer_occupancy, rx_data, overrun, underrun);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
      checks++;
      if (buffer_occupancy !== 7'd0) begin
         $display("FAIL reset_occ: got %0d expected 0", buffer_occupancy); errors++;
      end
      checks++;
      if (overrun !== 1'b0 || underrun !== 1'b0) begin
         $display("FAIL reset_flags: got ovf=%0b unf=%0b expected 0/0", overrun, underrun); errors++;
      end
      checks++;
      if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
         $display("FAIL reset_data: got rx=%02h tx=%02h expected 00/00", rx_data, tx_packet_data); errors++;
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 64; i++) begin
         drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         checks++;
         if (buffer_occupancy !== 7'(i)) begin
            $display("FAIL fill_occ[%0d]: got %0d expected %0d", i, buffer_occupancy, i); errors++;
         end
         checks++;
         if (rx_data !== 8'h01 || overrun !== 1'b0) begin
            $display("FAIL fill_head[%0d]: got rx=%02h ovf=%0b expected 01/0", i, rx_data, overrun); errors++;
         end
      end
   endtask

   task automatic test_full_wrap();
      logic [7:0] exp_b;
      logic [7:0] rnd;
      drive(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      checks++;
      if (overrun !== 1'b1 || buffer_occupancy !== 7'd64) begin
         $display("FAIL full_drop: got ovf=%0b occ=%0d expected 1/64", overrun, buffer_occupancy); errors++;
      end
      for (int i = 0; i < 64; i++) begin
         exp_b = model[0];
         checks++;
         if (rx_data !== exp_b || exp_b !== 8'(i + 1)) begin
            $display("FAIL drain[%0d]: got %02h expected %02h", i, rx_data, 8'(i + 1)); errors++;
         end
         drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checks++;
      if (rx_data !== 8'h00 || buffer_occupancy !== 7'd0) begin
         $display("FAIL drained: got rx=%02h occ=%0d expected 00/0", rx_data, buffer_occupancy); errors++;
      end
      for (int i = 0; i < 100; i++) begin
         rnd = 8'($urandom_range(0, 255));
         drive(1'b1, rnd, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         exp_b = model[0];
         checks++;
         if (tx_packet_data !== exp_b || rx_data !== exp_b) begin
            $display("FAIL wrap[%0d]: got rx=%02h tx=%02h expected %02h", i, rx_data, tx_packet_data, exp_b); errors++;
         end
         drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (buffer_occupancy !== 7'd0 || underrun !== 1'b0) begin
         $display("FAIL wrap_end: got occ=%0d unf=%0b expected 0/0", buffer_occupancy, underrun); errors++;
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_b;
      logic [7:0] last_b;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++)
         drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (buffer_occupancy !== 7'd64 || overrun !== 1'b0 || underrun !== 1'b0) begin
         $display("FAIL full_pushpop: got occ=%0d ovf=%0b unf=%0b expected 64/0/0",
                  buffer_occupancy, overrun, underrun); errors++;
      end
      last_b = 8'h00;
      for (int i = 0; i < 64; i++) begin
         exp_b = model[0];
         checks++;
         if (rx_data !== exp_b) begin
            $display("FAIL full_drain[%0d]: got %02h expected %02h", i, rx_data, exp_b); errors++;
         end
         last_b = rx_data;
         drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checks++;
      if (last_b !== 8'h55) begin
         $display("FAIL full_last: got %02h expected 55", last_b); errors++;
      end
      drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++;
      if (buffer_occupancy !== 7'd1 || underrun !== 1'b1 || tx_packet_data !== 8'h77) begin
         $display("FAIL empty_pushpop: got occ=%0d unf=%0b tx=%02h expected 1/1/77",
                  buffer_occupancy, underrun, tx_packet_data); errors++;
      end
      checks++;
      if (underrun !== model_unf || overrun !== model_ovf) begin
         $display("FAIL empty_flags: got ovf=%0b unf=%0b expected %0b/%0b",
                  overrun, underrun, model_ovf, model_unf); errors++;
      end
   endtask

   task automatic test_push_conflict();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      checks++;
      if (buffer_occupancy !== 7'd1 || rx_data !== 8'h22 || overrun !== 1'b1) begin
         $display("FAIL push_conflict: got occ=%0d head=%02h ovf=%0b expected 1/22/1",
                  buffer_occupancy, rx_data, overrun); errors++;
      end
   endtask

   task automatic test_clear_burst();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         drive(1'b0, 8'h00, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (buffer_occupancy !== 7'd10 || underrun !== 1'b1) begin
         $display("FAIL burst_pre: got occ=%0d unf=%0b expected 10/1", buffer_occupancy, underrun); errors++;
      end
      drive(1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++;
      if (buffer_occupancy !== 7'd0 || overrun !== 1'b0 || underrun !== 1'b0) begin
         $display("FAIL clear_state: got occ=%0d ovf=%0b unf=%0b expected 0/0/0",
                  buffer_occupancy, overrun, underrun); errors++;
      end
      checks++;
      if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
         $display("FAIL clear_data: got rx=%02h tx=%02h expected 00/00", rx_data, tx_packet_data); errors++;
      end
      drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (rx_data !== 8'h33 || buffer_occupancy !== 7'd1) begin
         $display("FAIL clear_next: got rx=%02h occ=%0d expected 33/1", rx_data, buffer_occupancy); errors++;
      end
   endtask

   task automatic test_sync_reset();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)
         drive(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (buffer_occupancy !== 7'd5 || rx_data !== model[0]) begin
         $display("FAIL glitch_rst: got occ=%0d head=%02h expected 5/%02h",
                  buffer_occupancy, rx_data, model[0]); errors++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model.delete();
      checks++;
      if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00) begin
         $display("FAIL held_rst: got occ=%0d rx=%02h expected 0/00", buffer_occupancy, rx_data); errors++;
      end
   endtask

   initial begin
      rst                  = 1'b0;
      clear                = 1'b0;
      store_tx_data        = 1'b0;
      tx_data              = 8'h00;
      get_rx_data          = 1'b0;
      store_rx_packet_data = 1'b0;
      rx_packet_data       = 8'h00;
      get_tx_packet_data   = 1'b0;
      model_ovf            = 1'b0;
      model_unf            = 1'b0;
      test_reset();
      test_fill();
      test_full_wrap();
      test_simultaneous();
      test_push_conflict();
      test_clear_burst();
      test_sync_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

Single-clock, 64-byte circular FIFO sitting between the AHB-Lite slave and the USB RX/TX packet engines. The RX engine pushes received payload bytes that the AHB side pops through `get_rx_data`. The AHB side pushes outgoing payload bytes through `store_tx_data`, and the TX engine pops them. It provides the `buffer_occupancy` count and the `clear` flush consumed and driven by the AHB slave.

## Interface
- `DEPTH`, default 64: number of byte entries; must be a power of two.
- `ADDR_W`, default 6: log2(`DEPTH`); pointer width.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset is synchronous and active-high, sampled on the `clk` rising edge.
- `clear` input 1: flush pulse from the AHB slave.
- `store_tx_data` input 1: AHB-side push strobe.
- `tx_data` input 8: AHB-side push byte.
- `get_rx_data` input 1: AHB-side pop strobe.
- `rx_data` output 8: head byte presented to the AHB side.
- `store_rx_packet_data` input 1: RX engine push strobe.
- `rx_packet_data` input 8: RX engine push byte.
- `get_tx_packet_data` input 1: TX engine pop strobe.
- `tx_packet_data` output 8: head byte presented to the TX engine.
- `buffer_occupancy` output `ADDR_W`+1 (7): current entry count, range 0..64.
- `overrun` output 1: sticky flag, set by a dropped push.
- `underrun` output 1: sticky flag, set by a dropped pop.

## Operation
- **State:** `wr_ptr` and `rd_ptr` are `ADDR_W` bits each; `count` is `ADDR_W`+1 bits; memory is `DEPTH` x 8, not reset.
- **Pointer wrap:** both pointers wrap naturally from 63 to 0.
- **Occupancy:** `buffer_occupancy` is `count`. Full is `count == DEPTH`; empty is `count == 0`.
- **Push arbitration:** `push = store_rx_packet_data | store_tx_data`.
  - If both strobes are high, the RX byte is written.
  - The AHB byte is dropped and `overrun` is set.
- **Pop arbitration:** `pop = get_tx_packet_data | get_rx_data`; a pop removes exactly one entry even if both strobes are high.
- **Read data:** first-word fall-through.
  - `rx_data` and `tx_packet_data` both equal `mem[rd_ptr]` combinationally when not empty.
  - Both are 8'h00 when empty.
- **Push accept rule:** a push is accepted if not full, or if full and an accepted pop occurs in the same cycle. Otherwise it is dropped and `overrun` is set.
- **Pop accept rule:** a pop is accepted if not empty; otherwise it is dropped and `underrun` is set.
  - There is no bypass: push and pop in the same cycle on an empty buffer accepts the push, drops the pop, and leaves `count` at 1.
- **Count update:** accepted push only gives +1; accepted pop only gives -1; both, or neither, leaves `count` unchanged.
- **`clear`:** zeroes `wr_ptr`, `rd_ptr`, `count`, `overrun` and `underrun`.
  - `clear` has priority over any same-cycle push or pop; those are discarded without setting flags.
- **`rst`:** same effect as `clear`, and has priority over `clear`.
- **Flags:** `overrun` and `underrun` stay set until `clear` or `rst`.

## Timing
- **Reset values:** `buffer_occupancy` = 0, `overrun` = 0, `underrun` = 0, `rx_data` = 8'h00, `tx_packet_data` = 8'h00.
  - These values hold from the first rising edge with `rst` high.
  - They remain while `rst` stays high.
- **Push latency:** a byte pushed in cycle N is visible on the read outputs and counted in `buffer_occupancy` in cycle N+1.
- **Pop latency:** in cycle N the popping block samples the head byte. The next byte (or 8'h00) appears in cycle N+1.
- **Strobes:** all strobes are single-cycle qualifiers. A strobe held high for k cycles performs k operations.
- **Flag latency:** flags assert in the cycle after the offending strobe.
- **Reset mid-operation:** `rst` or `clear` asserted during a burst takes effect at that edge. Buffer contents are abandoned, and the next push lands at entry 0.

## Test plan
- **Reset and fill:** assert `rst` 2 cycles, then push 0x01..0x40 via `store_rx_packet_data`.
  - Required: `buffer_occupancy` steps 1..64.
  - Required: `rx_data` = 0x01 throughout.
  - Required: `overrun` = 0.
- **Full and wrap:** with the buffer full, push 0xAA alone.
  - Required: `overrun` = 1 and count stays 64.
  - Then pop 64 times via `get_rx_data`. Required: bytes 0x01..0x40 in order, then `rx_data` = 0x00 and count = 0.
  - Repeat 100 push/pop pairs to exercise pointer wrap.
- **Simultaneous operations:**
  - Full buffer, push 0x55 with pop in the same cycle: count stays 64, no flag, and 0x55 is read out last.
  - Empty buffer, push 0x77 with pop in the same cycle: count = 1, `underrun` = 1, `tx_packet_data` = 0x77.
- **Push conflict:** `store_tx_data` (0x11) and `store_rx_packet_data` (0x22) in the same cycle.
  - Required: count +1, head = 0x22, `overrun` = 1.
- **`clear` mid-burst:** push 10 bytes; assert `clear` in the same cycle as a push of 0x99.
  - Required: count = 0, flags = 0, outputs = 0x00.
  - The next push of 0x33 is read back first.
- **Synchronous reset check:** pulse `rst` for less than one cycle between edges with the buffer at 5 entries.
  - Required: no change.
  - Then hold `rst` high across an edge. Required: count = 0 at that edge.
